pipe_hazard_arbiter: RTL and testbench

Parametrised stall/flush arbiter for the in-order pipeline, generalising the fixed six-stage hazard controller to NSTAGE stages and NREQ prioritised hazard sources.
- Each source carries its own stall and flush mask on ports, so new hazard classes need no RTL change.
- Adds state the previous controller lacks: one-cycle force-advance after a blocking source releases, pending latches for single-cycle flush pulses, and a stall watchdog.
- Sits beside the stage registers and drives every stage's stall/flush enable.

---
 rtl/pipe_ctrl_pkg.sv | 43 ++++
 rtl/pipe_prio_enc.sv | 17 +
 rtl/pipe_hazard_arbiter.sv | 80 ++++++++
 tb/tb_pipe_hazard_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stage/source indices and default hazard masks for the pipeline controller.
// No ports; imported by pipe_hazard_arbiter.
package pipe_ctrl_pkg;
    localparam int NSTAGE_DEF = 6;
    localparam int NREQ_DEF   = 10;
    typedef logic [NSTAGE_DEF-1:0] stage_vec_t;
    localparam int STG_PC    = 0;
    localparam int STG_PREIF = 1;
    localparam int STG_IFID  = 2;
    localparam int STG_IDEX  = 3;
    localparam int STG_EXMEM = 4;
    localparam int STG_MEMWB = 5;
    localparam int SRC_RAM_MEM    = 0;
    localparam int SRC_NEXT_PREIF = 1;
    localparam int SRC_RAM_IF     = 2;
    localparam int SRC_TRAP_FLUSH = 3;
    localparam int SRC_TRAP_STALL = 4;
    localparam int SRC_JUMP       = 5;
    localparam int SRC_MULDIV     = 6;
    localparam int SRC_LOAD_USE   = 7;
    localparam int SRC_COMPRESS   = 8;
    localparam stage_vec_t STALL_RAM_MEM    = 6'b001111;
    localparam stage_vec_t FLUSH_RAM_MEM    = 6'b010000;
    localparam stage_vec_t STALL_NEXT_PREIF = 6'b001111;
    localparam stage_vec_t FLUSH_NEXT_PREIF = 6'b000000;
    localparam stage_vec_t STALL_RAM_IF     = 6'b000011;
    localparam stage_vec_t FLUSH_RAM_IF     = 6'b000100;
    localparam stage_vec_t STALL_TRAP_FLUSH = 6'b000000;
    localparam stage_vec_t FLUSH_TRAP_FLUSH = 6'b011110;
    localparam stage_vec_t STALL_TRAP_STALL = 6'b001111;
    localparam stage_vec_t FLUSH_TRAP_STALL = 6'b000000;
    localparam stage_vec_t STALL_JUMP       = 6'b000000;
    localparam stage_vec_t FLUSH_JUMP       = 6'b000110;
    localparam stage_vec_t STALL_MULDIV     = 6'b000111;
    localparam stage_vec_t FLUSH_MULDIV     = 6'b001000;
    localparam stage_vec_t STALL_LOAD_USE   = 6'b000111;
    localparam stage_vec_t FLUSH_LOAD_USE   = 6'b001000;
    localparam stage_vec_t STALL_COMPRESS   = 6'b000001;
    localparam stage_vec_t FLUSH_COMPRESS   = 6'b000010;
    function automatic stage_vec_t stg_bit(input int s);
        return stage_vec_t'(1) << s;
    endfunction
endpackage

// File: rtl/pipe_prio_enc.sv
// pipe_prio_enc: lowest-index-wins priority encoder.
// Ports: req_i request bits; valid_o any request; idx_o index of lowest set bit (0 when none).
module pipe_prio_enc #(
    parameter int N = 10
) (
    input  logic [N-1:0]         req_i,
    output logic                 valid_o,
    output logic [$clog2(N)-1:0] idx_o
);
    localparam int W = $clog2(N);
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) idx_o = W'(i);
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/pipe_hazard_arbiter.sv
// pipe_hazard_arbiter: prioritised stall/flush arbiter driving every pipeline stage register.
// Build option: define PIPE_HAZARD_WDT_EN to build the stall watchdog (otherwise wdt_timeout_o=0).
// Ports: clk; rst sync active-low; req_valid_i per-source requests; req_stall_i/req_flush_i
// per-source masks (source k at [k*NSTAGE +: NSTAGE]); stall_o/flush_o stage enables;
// winner_valid_o/winner_o served source; force_adv_o override active; wdt_timeout_o sticky timeout.
module pipe_hazard_arbiter
    import pipe_ctrl_pkg::*;
#(
    parameter int                 NSTAGE    = NSTAGE_DEF,
    parameter int                 NREQ      = NREQ_DEF,
    parameter logic [NSTAGE-1:0]  RST_FLUSH = 6'b011111,
    parameter int                 FA_SRC    = SRC_RAM_MEM,
    parameter logic [NREQ-1:0]    FA_APPLY  = 10'b0000000110,
    parameter logic [NSTAGE-1:0]  FA_STALL  = 6'b000011,
    parameter logic [NSTAGE-1:0]  FA_FLUSH  = 6'b000100,
    parameter logic [NREQ-1:0]    STICKY    = 10'b0000011000,
    parameter int                 WDT_LIMIT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*NSTAGE-1:0]   req_stall_i,
    input  logic [NREQ*NSTAGE-1:0]   req_flush_i,
    output logic [NSTAGE-1:0]        stall_o,
    output logic [NSTAGE-1:0]        flush_o,
    output logic                     winner_valid_o,
    output logic [$clog2(NREQ)-1:0]  winner_o,
    output logic                     force_adv_o,
    output logic                     wdt_timeout_o
);
    localparam int WIDX = $clog2(NREQ);
    logic [NREQ-1:0] r_pending;
    logic            r_prev_fa;
    logic [NREQ-1:0] w_eff;
    logic [NREQ-1:0] w_served;
    logic            w_win_v;
    logic [WIDX-1:0] w_win;
    logic            w_fa;
    assign w_eff = req_valid_i | r_pending;
    pipe_prio_enc #(.N(NREQ)) u_prio (
        .req_i   (w_eff),
        .valid_o (w_win_v),
        .idx_o   (w_win)
    );
    // Override fires only in the cycle right after FA_SRC drops, and only for listed winners.
    assign w_fa           = rst && w_win_v && r_prev_fa && !req_valid_i[FA_SRC] && FA_APPLY[w_win];
    assign stall_o        = (!rst || !w_win_v) ? '0 : w_fa ? FA_STALL : req_stall_i[int'(w_win)*NSTAGE +: NSTAGE];
    assign flush_o        = !rst ? RST_FLUSH : !w_win_v ? '0 : w_fa ? FA_FLUSH : req_flush_i[int'(w_win)*NSTAGE +: NSTAGE];
    assign winner_valid_o = rst && w_win_v;
    assign winner_o       = winner_valid_o ? w_win : '0;
    assign force_adv_o    = w_fa;
    assign w_served       = w_win_v ? (NREQ'(1) << w_win) : '0;
    // Serving clears the latch even if the same source re-requests in that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_fa <= 1'b0;
            r_pending <= '0;
        end else begin
            r_prev_fa <= req_valid_i[FA_SRC];
            r_pending <= (r_pending | req_valid_i) & STICKY & ~w_served;
        end
    end
`ifdef PIPE_HAZARD_WDT_EN
    localparam int WDW = $clog2(WDT_LIMIT + 1);
    logic [WDW-1:0] r_wdt_cnt;
    logic           r_wdt;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdt_cnt <= '0;
            r_wdt     <= 1'b0;
        end else begin
            r_wdt_cnt <= !stall_o[STG_PC] ? '0 : (r_wdt_cnt == WDW'(WDT_LIMIT)) ? r_wdt_cnt : r_wdt_cnt + 1'b1;
            if (r_wdt_cnt == WDW'(WDT_LIMIT)) r_wdt <= 1'b1;
        end
    end
    assign wdt_timeout_o = rst && r_wdt;
`else
    assign wdt_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_hazard_arbiter.sv
// tb_pipe_hazard_arbiter: table vectors, hand sequences and randomized checks against a reference model.
module tb_pipe_hazard_arbiter;
    localparam int LIM = 8;
`ifdef PIPE_HAZARD_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_stall, req_flush;
    logic [5:0]  stall_o, flush_o;
    logic        winner_valid_o, force_adv_o, wdt_timeout_o;
    logic [1:0]  winner_o;
    int n_cmp = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    pipe_hazard_arbiter #(
        .NSTAGE(6), .NREQ(4), .RST_FLUSH(6'b011111), .FA_SRC(0), .FA_APPLY(4'b0010),
        .FA_STALL(6'b000011), .FA_FLUSH(6'b000100), .STICKY(4'b0100), .WDT_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_stall_i(req_stall), .req_flush_i(req_flush),
        .stall_o(stall_o), .flush_o(flush_o), .winner_valid_o(winner_valid_o), .winner_o(winner_o),
        .force_adv_o(force_adv_o), .wdt_timeout_o(wdt_timeout_o)
    );
    // Reference model state: last FA_SRC level, outstanding sticky pulses, current stall run length.
    logic       m_prev_fa = 1'b0;
    logic [3:0] m_pend = '0;
    int         m_run = 0;
    logic       m_wdt = 1'b0;
    logic [5:0] e_s, e_f;
    logic       e_wv, e_fa;
    logic [1:0] e_w;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask
    task automatic model_eval();
        int w;
        w = -1;
        e_s = '0; e_f = '0; e_wv = 1'b0; e_w = '0; e_fa = 1'b0;
        if (!rst) begin
            e_f = 6'b011111;
            return;
        end
        for (int k = 0; k < 4; k++)
            if (w < 0 && (req_valid[k] || m_pend[k])) w = k;
        if (w < 0) return;
        e_wv = 1'b1;
        e_w  = 2'(w);
        e_fa = m_prev_fa && !req_valid[0] && (w == 1);
        e_s  = e_fa ? 6'b000011 : req_stall[w*6 +: 6];
        e_f  = e_fa ? 6'b000100 : req_flush[w*6 +: 6];
    endtask
    task automatic model_edge();
        if (!rst) begin
            m_prev_fa = 1'b0; m_pend = '0; m_run = 0; m_wdt = 1'b0;
        end else begin
            m_prev_fa = req_valid[0];
            if (req_valid[2]) m_pend[2] = 1'b1;
            if (e_wv && e_w == 2) m_pend[2] = 1'b0;
            if (WDT_ON && m_run >= LIM) m_wdt = 1'b1;
            m_run = e_s[0] ? m_run + 1 : 0;
        end
    endtask
    task automatic drive_check(input logic r, input logic [3:0] v, input string tag);
        rst = r;
        req_valid = v;
        #3;
        model_eval();
        chk({tag, ".stall"}, 32'(stall_o), 32'(e_s));
        chk({tag, ".flush"}, 32'(flush_o), 32'(e_f));
        chk({tag, ".wvalid"}, 32'(winner_valid_o), 32'(e_wv));
        chk({tag, ".winner"}, 32'(winner_o), 32'(e_w));
        chk({tag, ".fa"}, 32'(force_adv_o), 32'(e_fa));
        chk({tag, ".wdt"}, 32'(wdt_timeout_o), 32'(m_wdt));
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask
    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [5:0] s;
        logic [5:0] f;
        logic       wv;
        logic [1:0] w;
        logic       fa;
    } vec_t;
    function automatic vec_t mk(logic r, logic [3:0] v, logic [5:0] s, logic [5:0] f, logic wv, logic [1:0] w, logic fa);
        vec_t x;
        x.r = r; x.v = v; x.s = s; x.f = f; x.wv = wv; x.w = w; x.fa = fa;
        return x;
    endfunction
    initial begin
        vec_t tbl[$];
        int hold;
        tbl.push_back(mk(0, 4'b1111, 6'b000000, 6'b011111, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0101, 6'b000000, 6'b011111, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0011, 6'b000000, 6'b011111, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 6'b000000, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 6'b001111, 6'b010000, 1, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 4'b0001, 6'b001111, 6'b010000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0010, 6'b000011, 6'b000100, 1, 1, 1));
        tbl.push_back(mk(1, 4'b0010, 6'b001111, 6'b000000, 1, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 6'b000000, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0101, 6'b001111, 6'b010000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 6'b001111, 6'b010000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 6'b001111, 6'b010000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 6'b000010, 6'b001110, 1, 2, 0));
        tbl.push_back(mk(1, 4'b0000, 6'b000000, 6'b000000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0101, 6'b001111, 6'b010000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 6'b001111, 6'b010000, 1, 0, 0));
        tbl.push_back(mk(0, 4'b0001, 6'b000000, 6'b011111, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 6'b000000, 6'b000000, 0, 0, 0));
        rst = 1'b0;
        req_valid = '0;
        req_stall = {6'b000011, 6'b000010, 6'b001111, 6'b001111};
        req_flush = {6'b000100, 6'b001110, 6'b000000, 6'b010000};
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive_check(tbl[i].r, tbl[i].v, $sformatf("vec%0d", i));
            chk($sformatf("tbl%0d.stall", i), 32'(stall_o), 32'(tbl[i].s));
            chk($sformatf("tbl%0d.flush", i), 32'(flush_o), 32'(tbl[i].f));
            chk($sformatf("tbl%0d.wvalid", i), 32'(winner_valid_o), 32'(tbl[i].wv));
            chk($sformatf("tbl%0d.winner", i), 32'(winner_o), 32'(tbl[i].w));
            chk($sformatf("tbl%0d.fa", i), 32'(force_adv_o), 32'(tbl[i].fa));
            tick();
        end
        drive_check(1'b0, 4'b0000, "wdt_rst");
        tick();
        for (int i = 0; i < 9; i++) begin
            drive_check(1'b1, 4'b0001, $sformatf("wdt_hold%0d", i));
            chk($sformatf("wdt_low%0d", i), 32'(wdt_timeout_o), 32'(0));
            tick();
        end
        drive_check(1'b1, 4'b0000, "wdt_after");
        chk("wdt_rise", 32'(wdt_timeout_o), 32'(WDT_ON));
        tick();
        drive_check(1'b1, 4'b0000, "wdt_held");
        chk("wdt_stay", 32'(wdt_timeout_o), 32'(WDT_ON));
        tick();
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            logic [3:0] v;
            if ($urandom_range(0, 3) == 0) req_stall = 24'($urandom);
            if ($urandom_range(0, 3) == 0) req_flush = 24'($urandom);
            if (hold == 0 && $urandom_range(0, 19) == 0) hold = $urandom_range(3, 14);
            v = 4'($urandom) & 4'($urandom);
            if (hold > 0) begin
                v[0] = 1'b1;
                req_stall[0] = 1'b1;
                hold--;
            end
            drive_check($urandom_range(0, 49) != 0, v, $sformatf("rnd%0d", i));
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
